// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: operation codes, predictor
// counter type and its reset value.
package branch_pkg;

    localparam logic [4:0] BR_BEQ   = 5'd1;
    localparam logic [4:0] BR_BNE   = 5'd2;
    localparam logic [4:0] BR_BLT   = 5'd3;
    localparam logic [4:0] BR_BGE   = 5'd4;
    localparam logic [4:0] BR_BLTU  = 5'd5;
    localparam logic [4:0] BR_BGEU  = 5'd6;
    localparam logic [4:0] BR_JAL   = 5'd7;
    localparam logic [4:0] ALU_JALR = 5'd8;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_RST = 2'b01;

    function automatic logic is_cond_br(input logic [4:0] fn);
        return (fn == BR_BEQ)  || (fn == BR_BNE)  || (fn == BR_BLT) ||
               (fn == BR_BGE)  || (fn == BR_BLTU) || (fn == BR_BGEU);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: BHT_DEPTH 2-bit saturating counters indexed by
// pc[log2(BHT_DEPTH)+1:2]; combinational lookup, one update port.
module branch_bht
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_ctr_t ctr [BHT_DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_pc_bits;

    function automatic bht_ctr_t sat_update(input bht_ctr_t cur, input logic taken);
        if (taken)
            return (cur == 2'b11) ? cur : cur + 2'b01;
        else
            return (cur == 2'b00) ? cur : cur - 2'b01;
    endfunction

    assign rd_idx = lookup_pc[IDX_W+1:2];
    assign wr_idx = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    // Read sees the counter before any same-cycle update lands.
    assign lookup_taken = ctr[rd_idx][1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                ctr[i] <= BHT_CTR_RST;
        end else if (upd_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution with one output register stage and optional dynamic
// predictor, enabled by defining BRANCH_UNIT_BHT_EN (static not-taken otherwise).
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      exe_fn,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            jump_flag,
    output logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] link_data,
    output logic            mispredict,
    output logic            misalign,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
);

    logic signed [XLEN-1:0] rs1_s_p0;
    logic signed [XLEN-1:0] rs2_s_p0;
    logic                   taken_p0;
    logic                   is_jalr_p0;
    logic [XLEN-1:0]        link_p0;
    logic [XLEN-1:0]        br_tgt_p0;
    logic [XLEN-1:0]        jalr_tgt_p0;
    logic [XLEN-1:0]        tgt_p0;
    logic                   misalign_p0;
    logic                   mispredict_p0;
    logic                   accept;

    logic                   vld_p1;
    logic                   jump_p1;
    logic [XLEN-1:0]        tgt_p1;
    logic [XLEN-1:0]        link_p1;
    logic                   mispredict_p1;
    logic                   misalign_p1;

    assign rs1_s_p0 = rs1_data;
    assign rs2_s_p0 = rs2_data;

    always_comb begin
        taken_p0   = 1'b0;
        is_jalr_p0 = 1'b0;
        case (exe_fn)
            BR_BEQ:   taken_p0 = (rs1_data == rs2_data);
            BR_BNE:   taken_p0 = (rs1_data != rs2_data);
            BR_BLT:   taken_p0 = (rs1_s_p0 <  rs2_s_p0);
            BR_BGE:   taken_p0 = (rs1_s_p0 >= rs2_s_p0);
            BR_BLTU:  taken_p0 = (rs1_data <  rs2_data);
            BR_BGEU:  taken_p0 = (rs1_data >= rs2_data);
            BR_JAL:   taken_p0 = 1'b1;
            ALU_JALR: begin
                taken_p0   = 1'b1;
                is_jalr_p0 = 1'b1;
            end
            default:  taken_p0 = 1'b0;
        endcase
    end

    assign link_p0     = pc + XLEN'(4);
    assign br_tgt_p0   = pc + imm;
    assign jalr_tgt_p0 = (rs1_data + imm) & ~XLEN'(1);
    assign tgt_p0      = !taken_p0  ? link_p0 :
                         is_jalr_p0 ? jalr_tgt_p0 : br_tgt_p0;

    // Only a taken redirect can fault; a fault always counts as a mispredict.
    assign misalign_p0   = taken_p0 && (tgt_p0[1:0] != 2'b00);
    assign mispredict_p0 = (taken_p0 != pred_taken_in) || misalign_p0;

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // ---- stage p0 -> p1 : output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            jump_p1       <= 1'b0;
            tgt_p1        <= '0;
            link_p1       <= '0;
            mispredict_p1 <= 1'b0;
            misalign_p1   <= 1'b0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (in_ready)
                vld_p1 <= in_valid;
            if (accept) begin
                jump_p1       <= taken_p0;
                tgt_p1        <= tgt_p0;
                link_p1       <= link_p0;
                mispredict_p1 <= mispredict_p0;
                misalign_p1   <= misalign_p0;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign jump_flag   = jump_p1;
    assign jump_target = tgt_p1;
    assign link_data   = link_p1;
    assign mispredict  = mispredict_p1;
    assign misalign    = misalign_p1;

`ifdef BRANCH_UNIT_BHT_EN
    logic            cond_p1;
    logic [XLEN-1:0] pc_p1;
    logic            bht_upd;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cond_p1 <= 1'b0;
        else if (accept)
            cond_p1 <= is_cond_br(exe_fn);
    end

    always_ff @(posedge clk) begin
        if (accept)
            pc_p1 <= pc;
    end

    assign bht_upd = vld_p1 && out_ready && !flush && cond_p1;

    branch_bht #(
        .XLEN      (XLEN),
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .upd_en       (bht_upd),
        .upd_pc       (pc_p1),
        .upd_taken    (jump_p1)
    );
`else
    logic unused_lookup_pc;

    assign unused_lookup_pc = ^lookup_pc;
    assign lookup_taken     = 1'b0;
`endif

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and target width.
REQ-002 Parameter BHT_DEPTH, default 16: number of predictor entries; power of two, at least 2.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  request handshake.
REQ-006 exe_fn  in  5  operation code, encoded per branch_pkg.
REQ-007 pc, rs1_data, rs2_data, imm  in  XLEN each  instruction PC, operands and sign-extended immediate.
REQ-008 pred_taken_in  in  1  prediction made at fetch for this instruction.
REQ-009 flush  in  1  kills the held result.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 jump_flag  out  1  redirect taken.
REQ-012 jump_target  out  XLEN  redirect address.
REQ-013 link_data  out  XLEN  pc+4 for JAL/JALR.
REQ-014 mispredict  out  1  resolved direction differs from pred_taken_in.
REQ-015 misalign  out  1  taken target with target[1:0] != 0.
REQ-016 lookup_pc / lookup_taken  in / out  XLEN / 1  fetch-side predictor query.

Function
REQ-017 Conditions: BEQ ==, BNE !=, BLT signed <, BGE signed >=, BLTU unsigned <, BGEU unsigned >=; JAL and JALR always taken; every other exe_fn is not taken.
REQ-018 Targets: branches and JAL use pc+imm; JALR uses (rs1_data+imm) with bit 0 cleared; additions are modulo 2^XLEN; not-taken jump_target = pc+4.
REQ-019 One output register stage: a request accepted at edge N is presented with out_valid=1 from cycle N+1.
REQ-020 in_ready = !out_valid || out_ready, giving full throughput when out_ready is held 1.
REQ-021 Outputs are held stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 clears out_valid at the next edge and blocks acceptance that cycle; a flushed entry performs no BHT update.
REQ-023 When misalign=1, jump_flag is still reported and mispredict is forced to 1.
REQ-024 Data outputs are don't-care while out_valid=0.

Reset
REQ-025 While rst_n=0 at an edge: out_valid=0, and jump_flag, mispredict, misalign, jump_target and link_data are cleared to 0.
REQ-026 Every BHT counter resets to weakly-not-taken (2'b01).
REQ-027 Reset mid-transfer discards the held result.

Configuration
REQ-028 Macro BRANCH_UNIT_BHT_EN defined: a BHT_DEPTH-entry table of 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-029 With the BHT: lookup_taken = counter[1], read combinationally from lookup_pc.
REQ-030 With the BHT: at each output handshake (out_valid && out_ready && !flush) of a conditional branch, the counter increments on taken and decrements on not-taken, saturating at 0 and 3.
REQ-031 With the BHT: a lookup and an update of the same index in one cycle return the pre-update value.
REQ-032 Macro undefined: no table is built, lookup_taken=0 (static not-taken), and all other behaviour is identical.

Structure
REQ-033 branch_pkg holds the exe_fn codes (BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, ALU_JALR), the 2-bit counter typedef, and its reset constant.
REQ-034 The predictor table is the sub-module branch_bht, instantiated only under BRANCH_UNIT_BHT_EN.

Verification
REQ-035 BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> jump_flag=1 and jump_target=0x120; the same operands with BLTU -> jump_flag=0 and jump_target=0x104.
REQ-036 JALR with rs1=0x1001, imm=0x2 -> jump_target=0x1002, link_data=pc+4, misalign=1, mispredict=1.
REQ-037 Back-to-back requests with out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable for those 3 cycles, then both results delivered in order without loss.
REQ-038 flush asserted while out_valid=1 -> out_valid=0 on the next cycle and the BHT entry is unchanged.
REQ-039 BHT enabled, pc=0x40: three taken BEQ resolutions take the counter 01->10->11->11, lookup_taken=1 after the first; one not-taken then takes it to 10 and lookup_taken stays 1.
REQ-040 rst_n=0 for one edge while out_valid=1 -> out_valid=0 and all counters read back as 01.
